// File: rtl/m_controller_pkg.sv
// m_controller_pkg
//   Shared definitions for the RV32M multiply/divide unit: funct3 op codes,
//   controller state encoding, register-select encodings for m_registers,
//   multiplier operand-select encodings and the division iteration count.
//   Imported by m_controller and by the datapath/top of the M unit.

package m_controller_pkg;

   // RV32M operations, encoded exactly as funct3.
   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } op_t;

   // Controller states.
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_MUL_OP   = 3'd1,
      S_MUL_WAIT = 3'd2,
      S_MUL_CAP  = 3'd3,
      S_DIV_STEP = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   // Restoring division runs one quotient bit per cycle.
   localparam int M_DIV_STEPS = 32;
   localparam int STEP_W      = 5;

   // Select widths.
   localparam int MUX_R_LENGTH     = 3;
   localparam int MUX_D_LENGTH     = 2;
   localparam int MUX_Z_LENGTH     = 2;
   localparam int MUX_MULTA_LENGTH = 1;
   localparam int MUX_MULTB_LENGTH = 1;

   // R register (dividend / remainder / low product).
   localparam logic [MUX_R_LENGTH-1:0] MUX_R_KEEP       = 3'd0;
   localparam logic [MUX_R_LENGTH-1:0] MUX_R_A          = 3'd1;
   localparam logic [MUX_R_LENGTH-1:0] MUX_R_A_NEG      = 3'd2;
   localparam logic [MUX_R_LENGTH-1:0] MUX_R_SUB_KEEP   = 3'd3;
   localparam logic [MUX_R_LENGTH-1:0] MUX_R_MULT_LOWER = 3'd4;

   // D register (divisor, shifted right once per division step).
   localparam logic [MUX_D_LENGTH-1:0] MUX_D_KEEP  = 2'd0;
   localparam logic [MUX_D_LENGTH-1:0] MUX_D_B     = 2'd1;
   localparam logic [MUX_D_LENGTH-1:0] MUX_D_B_NEG = 2'd2;
   localparam logic [MUX_D_LENGTH-1:0] MUX_D_SHR   = 2'd3;

   // Z register (quotient / high product).
   localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_KEEP       = 2'd0;
   localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_ZERO       = 2'd1;
   localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_SHL_ADD    = 2'd2;
   localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_MULT_UPPER = 2'd3;

   // Multiplier operand extension.
   localparam logic [MUX_MULTA_LENGTH-1:0] MUX_MULTA_R_UNSIGNED = 1'b0;
   localparam logic [MUX_MULTA_LENGTH-1:0] MUX_MULTA_R_SIGNED   = 1'b1;
   localparam logic [MUX_MULTB_LENGTH-1:0] MUX_MULTB_D_UNSIGNED = 1'b0;
   localparam logic [MUX_MULTB_LENGTH-1:0] MUX_MULTB_D_SIGNED   = 1'b1;

   function automatic logic is_mul_op(input op_t op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
   endfunction

   function automatic logic is_signed_div_op(input op_t op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   // 1 selects Z (high product or quotient), 0 selects R.
   function automatic logic result_sel_of(input op_t op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU) ||
             (op == OP_DIV)  || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/m_controller.sv
// m_controller
//   Control FSM for the RV32M multiply/divide unit. Accepts a request on a
//   valid/ready handshake, loads operands into m_registers on the acceptance
//   edge, then runs either a 3-cycle multiply or a 32-step restoring division
//   and presents the result until the downstream handshake completes.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   in_valid / in_ready     request handshake (in_ready high only in IDLE)
//   funct3                  RV32M op code, sampled at acceptance
//   rs1_sign, rs2_sign      operand sign bits, sampled at acceptance
//   rs2_zero                divisor is zero, sampled at acceptance
//   sub_neg                 subtractor sign; consumed by the datapath only
//   mux_R, mux_D, mux_Z     register selects for m_registers
//   mux_multA, mux_multB    multiplier operand signedness selects
//   out_valid / out_ready   result handshake (out_valid high only in DONE)
//   result_sel              0 = R, 1 = Z
//   neg_result              top negates the selected result

module m_controller
   import m_controller_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [2:0]                  funct3,
   input  logic                        rs1_sign,
   input  logic                        rs2_sign,
   input  logic                        rs2_zero,
   input  logic                        sub_neg,
   output logic [MUX_R_LENGTH-1:0]     mux_R,
   output logic [MUX_D_LENGTH-1:0]     mux_D,
   output logic [MUX_Z_LENGTH-1:0]     mux_Z,
   output logic [MUX_MULTA_LENGTH-1:0] mux_multA,
   output logic [MUX_MULTB_LENGTH-1:0] mux_multB,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        result_sel,
   output logic                        neg_result
);

   state_t                      state;
   logic [STEP_W-1:0]           step_cnt;
   op_t                         op_class;
   logic [MUX_MULTA_LENGTH-1:0] mult_a_q;
   logic [MUX_MULTB_LENGTH-1:0] mult_b_q;

   op_t  op_in;
   logic in_mul_state;
   logic accept;
   logic neg_next;

   // The restoring-step decision is taken inside m_registers.
   logic unused_sub_neg;
   assign unused_sub_neg = sub_neg;

   assign op_in        = op_t'(funct3);
   assign accept       = (state == S_IDLE) && in_valid;
   assign in_ready     = (state == S_IDLE);
   assign out_valid    = (state == S_DONE);
   assign in_mul_state = (state == S_MUL_OP) || (state == S_MUL_WAIT) || (state == S_MUL_CAP);

   // Sign of the final result. A zero divisor leaves the quotient at all ones,
   // which is already the required value, so DIV must not negate it; the
   // remainder always takes the dividend's sign.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      neg_next = 1'b0;
      case (op_in)
         OP_DIV:  neg_next = (rs1_sign ^ rs2_sign) & ~rs2_zero;
         OP_REM:  neg_next = rs1_sign;
         default: neg_next = 1'b0;
      endcase
   end

   // Control state, step counter and registered result flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state      <= S_IDLE;
         step_cnt   <= '0;
         op_class   <= OP_MUL;
         result_sel <= 1'b0;
         neg_result <= 1'b0;
         mult_a_q   <= MUX_MULTA_R_UNSIGNED;
         mult_b_q   <= MUX_MULTB_D_UNSIGNED;
      end else begin
         // The multiplier selects keep the value they had in the last MUL state.
         if (in_mul_state) begin
            mult_a_q <= mux_multA;
            mult_b_q <= mux_multB;
         end

         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_class   <= op_in;
                  result_sel <= result_sel_of(op_in);
                  neg_result <= is_mul_op(op_in) ? 1'b0 : neg_next;
                  if (is_mul_op(op_in)) begin
                     state <= S_MUL_OP;
                  end else begin
                     state    <= S_DIV_STEP;
                     step_cnt <= STEP_W'(M_DIV_STEPS - 1);
                  end
               end
            end
            S_MUL_OP:   state <= S_MUL_WAIT;
            S_MUL_WAIT: state <= S_MUL_CAP;
            S_MUL_CAP:  state <= S_DONE;
            S_DIV_STEP: begin
               // Counter runs 31 down to 0, one quotient bit per cycle.
               if (step_cnt == '0) begin
                  state <= S_DONE;
               end else begin
                  step_cnt <= step_cnt - 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Register and multiplier selects. The load in IDLE is Mealy so that the
   // acceptance edge itself captures the operands.
   always_comb begin
      mux_R     = MUX_R_KEEP;
      mux_D     = MUX_D_KEEP;
      mux_Z     = MUX_Z_KEEP;
      mux_multA = mult_a_q;
      mux_multB = mult_b_q;

      case (state)
         S_IDLE: begin
            if (in_valid) begin
               mux_Z = MUX_Z_ZERO;
               if (is_signed_div_op(op_in)) begin
                  // Signed division runs on magnitudes; the sign is restored by the top.
                  mux_R = rs1_sign ? MUX_R_A_NEG : MUX_R_A;
                  mux_D = rs2_sign ? MUX_D_B_NEG : MUX_D_B;
               end else begin
                  mux_R = MUX_R_A;
                  mux_D = MUX_D_B;
               end
            end
         end
         S_MUL_OP, S_MUL_WAIT, S_MUL_CAP: begin
            mux_multA = ((op_class == OP_MULH) || (op_class == OP_MULHSU))
                        ? MUX_MULTA_R_SIGNED : MUX_MULTA_R_UNSIGNED;
            mux_multB = (op_class == OP_MULH) ? MUX_MULTB_D_SIGNED : MUX_MULTB_D_UNSIGNED;
            if (state == S_MUL_CAP) begin
               mux_R = MUX_R_MULT_LOWER;
               mux_Z = MUX_Z_MULT_UPPER;
            end
         end
         S_DIV_STEP: begin
            mux_R = MUX_R_SUB_KEEP;
            mux_D = MUX_D_SHR;
            mux_Z = MUX_Z_SHL_ADD;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_m_controller.sv
// tb_m_controller
//   Bench for m_controller. A small behavioural register model reacts to the
//   controller's selects, so the final negated/selected result can be compared
//   with hand-computed RV32M values alongside latency and handshake checks.

module tb_m_controller;
   import m_controller_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  funct3;
   logic        rs1_sign, rs2_sign, rs2_zero, sub_neg;
   logic [MUX_R_LENGTH-1:0]     mux_R;
   logic [MUX_D_LENGTH-1:0]     mux_D;
   logic [MUX_Z_LENGTH-1:0]     mux_Z;
   logic [MUX_MULTA_LENGTH-1:0] mux_multA;
   logic [MUX_MULTB_LENGTH-1:0] mux_multB;
   logic        out_valid, out_ready, result_sel, neg_result;

   always #5 clk = ~clk;

   m_controller dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .funct3     (funct3),
      .rs1_sign   (rs1_sign),
      .rs2_sign   (rs2_sign),
      .rs2_zero   (rs2_zero),
      .sub_neg    (sub_neg),
      .mux_R      (mux_R),
      .mux_D      (mux_D),
      .mux_Z      (mux_Z),
      .mux_multA  (mux_multA),
      .mux_multB  (mux_multB),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result_sel (result_sel),
      .neg_result (neg_result)
   );

   // ---------------- behavioural register model ----------------
   // D holds the divisor aligned at bit 31 so step i compares R with b << i;
   // its bits [62:31] are the multiplier's B operand.
   logic [31:0] a_in, b_in;
   logic [31:0] r_q, z_q;
   logic [63:0] d_q;
   logic [63:0] diff, op_a, op_b, prod;
   logic [31:0] sel_val, top_result;

   assign rs1_sign = a_in[31];
   assign rs2_sign = b_in[31];
   assign rs2_zero = (b_in == 32'd0);
   assign diff     = {32'd0, r_q} - d_q;
   assign sub_neg  = diff[63];
   assign op_a     = (mux_multA == MUX_MULTA_R_SIGNED) ? {{32{r_q[31]}}, r_q} : {32'd0, r_q};
   assign op_b     = (mux_multB == MUX_MULTB_D_SIGNED) ? {{32{d_q[62]}}, d_q[62:31]}
                                                       : {32'd0, d_q[62:31]};
   assign prod     = op_a * op_b;
   assign sel_val  = result_sel ? z_q : r_q;
   assign top_result = neg_result ? (32'd0 - sel_val) : sel_val;

   always @(posedge clk) begin
      if (!reset) begin
         case (mux_R)
            MUX_R_A:          r_q <= a_in;
            MUX_R_A_NEG:      r_q <= 32'd0 - a_in;
            MUX_R_SUB_KEEP:   if (!diff[63]) r_q <= diff[31:0];
            MUX_R_MULT_LOWER: r_q <= prod[31:0];
            default: ;
         endcase
         case (mux_D)
            MUX_D_B:     d_q <= {32'd0, b_in} << 31;
            MUX_D_B_NEG: d_q <= {32'd0, 32'd0 - b_in} << 31;
            MUX_D_SHR:   d_q <= d_q >> 1;
            default: ;
         endcase
         case (mux_Z)
            MUX_Z_ZERO:       z_q <= 32'd0;
            MUX_Z_SHL_ADD:    z_q <= {z_q[30:0], ~diff[63]};
            MUX_Z_MULT_UPPER: z_q <= prod[63:32];
            default: ;
         endcase
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      op_t         f;
      logic [31:0] a, b;
      logic [2:0]  ld_r;
      logic [1:0]  ld_d;
      logic        rsel, neg;
      logic [31:0] res;
      int          edges;
   } vec_t;

   function automatic vec_t mk(input op_t f, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] ld_r, input logic [1:0] ld_d,
                               input logic rsel, input logic neg, input logic [31:0] res);
      vec_t v;
      v.f = f; v.a = a; v.b = b; v.ld_r = ld_r; v.ld_d = ld_d;
      v.rsel = rsel; v.neg = neg; v.res = res;
      v.edges = is_mul_op(f) ? 4 : 33;
      return v;
   endfunction

   task automatic start_op(input op_t f, input logic [31:0] a, input logic [31:0] b);
      funct3   = f;
      a_in     = a;
      b_in     = b;
      in_valid = 1'b1;
   endtask

   // Waits for out_valid; edges counts clock edges from acceptance inclusive.
   task automatic wait_done(input string tag, inout int edges);
      while (!out_valid && edges < 100) begin
         @(posedge clk); #1;
         edges++;
      end
      if (!out_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout: out_valid never rose", tag);
      end
   endtask

   // Applies one request, checks load selects, latency and result, holds DONE
   // for 'stall' cycles with out_ready low, then completes the handshake.
   task automatic run_vec(input vec_t v, input string tag, input int stall);
      int edges;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " in_ready idle"}, in_ready, 1);
      start_op(v.f, v.a, v.b);
      #1;
      check({tag, " load R"}, mux_R, v.ld_r);
      check({tag, " load D"}, mux_D, v.ld_d);
      check({tag, " load Z"}, mux_Z, MUX_Z_ZERO);
      @(posedge clk); #1;
      in_valid = 1'b0;
      edges = 1;
      check({tag, " in_ready busy"}, in_ready, 0);
      wait_done(tag, edges);
      check({tag, " latency"}, edges, v.edges);
      check({tag, " result_sel"}, result_sel, v.rsel);
      check({tag, " neg_result"}, neg_result, v.neg);
      check({tag, " result"}, top_result, v.res);
      for (int s = 0; s < stall; s++) begin
         in_valid = 1'b1;   // a request offered during DONE must be ignored
         @(posedge clk); #1;
         check({tag, " stall out_valid"}, out_valid, 1);
         check({tag, " stall in_ready"}, in_ready, 0);
         check({tag, " stall selects"}, {29'd0, mux_R}, {29'd0, MUX_R_KEEP});
         check({tag, " stall D/Z"}, {mux_D, mux_Z}, {MUX_D_KEEP, MUX_Z_KEEP});
         check({tag, " stall result"}, top_result, v.res);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " back to idle"}, {out_valid, in_ready}, 2'b01);
   endtask

   vec_t vecs[15];

   initial begin
      int edges;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      funct3 = '0; a_in = '0; b_in = '0;
      r_q = '0; d_q = '0; z_q = '0;

      vecs[0]  = mk(OP_MULH,   32'hFFFF_FFFD, 32'd5,         MUX_R_A,     MUX_D_B,     1, 0, 32'hFFFF_FFFF);
      vecs[1]  = mk(OP_MULH,   32'd5,         32'hFFFF_FFFD, MUX_R_A,     MUX_D_B,     1, 0, 32'hFFFF_FFFF);
      vecs[2]  = mk(OP_MUL,    32'd6,         32'd7,         MUX_R_A,     MUX_D_B,     0, 0, 32'd42);
      vecs[3]  = mk(OP_MULHU,  32'hFFFF_FFFF, 32'd2,         MUX_R_A,     MUX_D_B,     1, 0, 32'd1);
      vecs[4]  = mk(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         MUX_R_A,     MUX_D_B,     1, 0, 32'hFFFF_FFFF);
      vecs[5]  = mk(OP_MULHSU, 32'd2,         32'hFFFF_FFFF, MUX_R_A,     MUX_D_B,     1, 0, 32'd1);
      vecs[6]  = mk(OP_DIV,    32'hFFFF_FFEC, 32'd3,         MUX_R_A_NEG, MUX_D_B,     1, 1, 32'hFFFF_FFFA);
      vecs[7]  = mk(OP_REM,    32'hFFFF_FFEC, 32'd3,         MUX_R_A_NEG, MUX_D_B,     0, 1, 32'hFFFF_FFFE);
      vecs[8]  = mk(OP_DIV,    32'd20,        32'hFFFF_FFFD, MUX_R_A,     MUX_D_B_NEG, 1, 1, 32'hFFFF_FFFA);
      vecs[9]  = mk(OP_DIVU,   32'd7,         32'd0,         MUX_R_A,     MUX_D_B,     1, 0, 32'hFFFF_FFFF);
      vecs[10] = mk(OP_DIV,    32'hFFFF_FFF9, 32'd0,         MUX_R_A_NEG, MUX_D_B,     1, 0, 32'hFFFF_FFFF);
      vecs[11] = mk(OP_REM,    32'hFFFF_FFF9, 32'd0,         MUX_R_A_NEG, MUX_D_B,     0, 1, 32'hFFFF_FFF9);
      vecs[12] = mk(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, MUX_R_A_NEG, MUX_D_B_NEG, 1, 0, 32'h8000_0000);
      vecs[13] = mk(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, MUX_R_A_NEG, MUX_D_B_NEG, 0, 1, 32'd0);
      vecs[14] = mk(OP_DIVU,   32'hFFFF_FFFF, 32'd2,         MUX_R_A,     MUX_D_B,     1, 0, 32'h7FFF_FFFF);

      // Reset values.
      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset result flags", {result_sel, neg_result}, 2'b00);
      check("reset selects", {mux_R, mux_D, mux_Z}, {MUX_R_KEEP, MUX_D_KEEP, MUX_Z_KEEP});
      check("reset mult selects", {mux_multA, mux_multB}, 2'b00);
      reset = 1'b0;

      // Table-driven vectors.
      for (int i = 0; i < 15; i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i), 0);
      end

      // DONE stall with out_ready low, then mult selects hold outside MUL states.
      run_vec(vecs[0], "stall", 5);
      check("mult selects hold", {mux_multA, mux_multB},
            {MUX_MULTA_R_SIGNED, MUX_MULTB_D_SIGNED});

      // Reset in the middle of a division.
      @(posedge clk); #1;
      start_op(OP_DIV, 32'hFFFF_FFEC, 32'd3);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("mid-div busy", in_ready, 0);
      reset = 1'b1;
      #1;
      check("mid-div reset in_ready", in_ready, 1);
      check("mid-div reset flags", {out_valid, result_sel, neg_result}, 3'b000);
      @(posedge clk); #1;
      reset = 1'b0;
      run_vec(mk(OP_DIVU, 32'd100, 32'd7, MUX_R_A, MUX_D_B, 1, 0, 32'd14), "after reset", 0);

      // Back-to-back with out_ready held high: exactly one IDLE bubble.
      @(posedge clk); #1;
      out_ready = 1'b1;
      start_op(OP_MUL, 32'd6, 32'd7);
      @(posedge clk); #1;
      in_valid = 1'b0;
      edges = 1;
      wait_done("b2b mul", edges);
      check("b2b mul result", top_result, 32'd42);
      start_op(OP_DIVU, 32'd9, 32'd2);
      #1;
      check("b2b no accept in DONE", in_ready, 0);
      @(posedge clk); #1;
      check("b2b bubble in_ready", in_ready, 1);
      check("b2b bubble load R", mux_R, MUX_R_A);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("b2b divu accepted", in_ready, 0);
      edges = 1;
      wait_done("b2b divu", edges);
      check("b2b divu latency", edges, 33);
      check("b2b divu result", top_result, 32'd4);
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("b2b final idle", {out_valid, in_ready}, 2'b01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global timeout");
      $fatal(1, "simulation time limit reached");
   end

endmodule
